ripple_count_checker: RTL
=========================

# ripple_count_checker

Synchronous consumer of the 4-bit ripple counter's `Q` bus. It samples the asynchronously rippling count into the `clock` domain through a two-stage register and presents a stable copy. It checks that successive samples advance legally, by hold or by +1 modulo 2^WIDTH. It also counts wrap-arounds and raises a sticky fault on any illegal step. It sits directly downstream of the counter in the stimulus/test fabric and feeds status to the monitor logic.

## Interface
- WIDTH, 4, width of the sampled count bus
- WRAP_W, 8, width of the wrap-around counter (saturating)
- clock  input  1  sampling clock, rising edge; the same net that drives the ripple counter
- clear  input  1  asynchronous, active-high reset
- enable  input  1  checking enable; when low, sampling continues but no checks, wraps or faults occur
- err_ack  input  1  one-cycle pulse that clears a fault and re-arms checking
- threshold  input  WIDTH  compare value for `match_pulse`
- q_in  input  WIDTH  raw ripple-counter output
- count_out  output  WIDTH  synchronized count (second sample stage)
- wrap_pulse  output  1  one-cycle pulse on a legal transition from (2^WIDTH−1) to 0
- wrap_count  output  WRAP_W  number of wraps since reset, saturating
- match_pulse  output  1  one-cycle pulse when `count_out` first becomes equal to `threshold`
- fault  output  1  sticky illegal-step flag
- fault_value  output  WIDTH  `count_out` value that caused the fault
- state  output  2  FSM state: 0 IDLE, 1 SYNC, 2 TRACK, 3 FAULT

## Operation
- Pipeline on every rising `clock`: s1 ← q_in, s2 ← s1, prev ← s2. `count_out` = s2.
- Sampling runs in every state, regardless of `enable`.
- FSM:
  - IDLE: when `enable`=1, go to SYNC and load sync_cnt=0.
  - SYNC: increment sync_cnt. After 2 cycles, go to TRACK, so that s2 and prev hold valid samples. `enable`=0 returns to IDLE.
  - TRACK: step = s2 − prev, modulo 2^WIDTH.
    - step of 0 or 1 is legal.
    - Any other step: go to FAULT, set `fault`=1, capture `fault_value`=s2.
    - `enable`=0: go to IDLE with no fault.
  - FAULT: hold until `err_ack`=1, then go to SYNC and clear `fault`. `fault_value` is retained until the next fault. `enable` is ignored in FAULT.
- wrap_pulse: asserted in TRACK when prev=2^WIDTH−1 and s2=0. On the same edge `wrap_count` increments, saturating at 2^WRAP_W−1.
- match_pulse: asserted in TRACK when s2=threshold and prev≠threshold. A legal hold at threshold does not re-pulse.
- Simultaneous events:
  - wrap and match may coincide when threshold=0; both pulse.
  - An illegal step produces no wrap_pulse or match_pulse on that cycle.
  - `err_ack` outside FAULT is ignored.
- All arithmetic is unsigned WIDTH-bit with natural wrap. `wrap_count` never rolls over.

## Timing
- Reset (`clear`=1, asynchronous) forces:
  - state=IDLE
  - s1=s2=prev=0, so count_out=0
  - wrap_pulse=0, match_pulse=0, wrap_count=0
  - fault=0, fault_value=0
- `clear` takes effect immediately, also mid-TRACK or mid-FAULT. Release takes effect at the next rising edge.
- Latency:
  - q_in → count_out: 2 rising edges.
  - q_in → wrap_pulse/match_pulse/fault: 3 rising edges. All three are registered outputs.
- `enable` rising edge → first check cycle: 3 edges (IDLE→SYNC, SYNC, SYNC→TRACK).
- `err_ack` sampled at edge N → state=SYNC and fault=0 after edge N. Checking resumes 2 edges later.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset mid-run: TRACK at count 9, pulse `clear` between edges → all outputs 0 and state=IDLE immediately, before the next edge.
- Free-running counter: q_in 0,1,…,15,0,1 with enable=1 and threshold=5.
  - count_out follows q_in with a delay of 2 edges.
  - One match_pulse per pass through 5.
  - wrap_pulse exactly once per 15→0.
  - wrap_count=3 after 3 full cycles.
  - fault stays 0.
- Counter held: drive q_in 0 for 10 cycles (the ripple counter's own clear held), then 1,2 → no fault and no extra match_pulse when threshold=0 is held.
- Skip fault: sequence 3,4,6 → fault=1, fault_value=6, state=FAULT on the third edge after 6 is applied. A further q_in sequence 7,8 keeps fault=1. Then err_ack → SYNC, fault=0, and checking resumes with no fault on a legal sequence.
- Backward step: 8→7 → fault=1, fault_value=7.
- Saturation: with WRAP_W=2, run 5 full wraps → wrap_count sticks at 3 while wrap_pulse still pulses 5 times.

Source files
------------

// File: rtl/ripple_count_checker.sv
// Synchronizes a rippling counter bus into the clock domain and
// checks that each sample holds or advances by one (mod 2^WIDTH).
//
// Ports:
//   clock, clear      sampling clock, async active-high reset
//   enable            arms checking (sampling always runs)
//   err_ack           clears a fault and re-arms via SYNC
//   threshold         compare value for match_pulse
//   q_in              raw ripple-counter bus
//   count_out         synchronized count (second stage)
//   wrap_pulse        one-cycle pulse on legal max -> 0
//   wrap_count        saturating number of wraps
//   match_pulse       one-cycle pulse on arrival at threshold
//   fault             sticky illegal-step flag
//   fault_value       sample that caused the last fault
//   state             0 IDLE, 1 SYNC, 2 TRACK, 3 FAULT
module ripple_count_checker #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              enable,
  input  logic              err_ack,
  input  logic [WIDTH-1:0]  threshold,
  input  logic [WIDTH-1:0]  q_in,
  output logic [WIDTH-1:0]  count_out,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              match_pulse,
  output logic              fault,
  output logic [WIDTH-1:0]  fault_value,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2,
    FLT   = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0]  MAX  = '1;
  localparam logic [WIDTH-1:0]  ONE  = WIDTH'(1);
  localparam logic [WRAP_W-1:0] WSAT = '1;

  state_e            state_q;
  logic [1:0]        sync_cnt_q;
  logic [WIDTH-1:0]  s1_q;
  logic [WIDTH-1:0]  s2_q;
  logic [WIDTH-1:0]  prev_q;
  logic              wrap_q;
  logic              match_q;
  logic              fault_q;
  logic [WIDTH-1:0]  fval_q;
  logic [WRAP_W-1:0] wcnt_q;
  logic [WRAP_W-1:0] wcnt_d;

  logic [WIDTH-1:0] step;
  logic             legal;
  logic             is_wrap;
  logic             is_match;

  // Modular difference: hold is 0, advance is 1, anything else is illegal.
  assign step     = s2_q - prev_q;
  assign legal    = (step == '0) || (step == ONE);
  assign is_wrap  = (prev_q == MAX) && (s2_q == '0);
  assign is_match = (s2_q == threshold) && (prev_q != threshold);
  assign wcnt_d   = (wcnt_q == WSAT) ? wcnt_q : wcnt_q + 1'b1;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      sync_cnt_q <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      prev_q     <= '0;
      wrap_q     <= 1'b0;
      match_q    <= 1'b0;
      fault_q    <= 1'b0;
      fval_q     <= '0;
      wcnt_q     <= '0;
    end else begin
      s1_q    <= q_in;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      wrap_q  <= 1'b0;
      match_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (enable) begin
            state_q    <= SYNC;
            sync_cnt_q <= '0;
          end
        end
        // Two cycles let s2 and prev refill with real samples.
        SYNC: begin
          if (!enable) begin
            state_q <= IDLE;
          end else begin
            sync_cnt_q <= sync_cnt_q + 2'd1;
            if (sync_cnt_q == 2'd1) state_q <= TRACK;
          end
        end
        TRACK: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if (!legal) begin
            state_q <= FLT;
            fault_q <= 1'b1;
            fval_q  <= s2_q;
          end else begin
            wrap_q  <= is_wrap;
            match_q <= is_match;
            if (is_wrap) wcnt_q <= wcnt_d;
          end
        end
        FLT: begin
          if (err_ack) begin
            state_q    <= SYNC;
            sync_cnt_q <= '0;
            fault_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign count_out   = s2_q;
  assign wrap_pulse  = wrap_q;
  assign wrap_count  = wcnt_q;
  assign match_pulse = match_q;
  assign fault       = fault_q;
  assign fault_value = fval_q;
  assign state       = state_q;

endmodule
